// File: rtl/instr_encode_loader.sv
// Packs decoded instruction fields into {opcode, reg1, low byte} words and streams them to program memory.
// Optional checksum output enabled by defining ENCODE_CHECKSUM_EN.
module instr_encode_loader #(
   parameter int WORD_WIDTH = 16,
   parameter int NIB_WIDTH  = 4,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] count,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_isaluop,
   input  logic [2:0]            in_aluop,
   input  logic [NIB_WIDTH-1:0]  in_opcode,
   input  logic [NIB_WIDTH-1:0]  in_reg1,
   input  logic [NIB_WIDTH-1:0]  in_reg2,
   input  logic [NIB_WIDTH-1:0]  in_reg3,
   input  logic                  in_use_bigval,
   input  logic [BYTE_WIDTH-1:0] in_bigval,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
`ifdef ENCODE_CHECKSUM_EN
   ,
   output logic [WORD_WIDTH-1:0] checksum
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   state_t state, state_next;

   logic [WORD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]        wr_ptr, rd_ptr;
   logic                  fifo_empty, fifo_full;

   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   remaining, accepted;

   logic                  session_start, take, legal, push, pop;
   logic [NIB_WIDTH-1:0]  opcode;
   logic [BYTE_WIDTH-1:0] low_byte;
   logic [WORD_WIDTH-1:0] packed_word;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign opcode      = in_isaluop ? {{(NIB_WIDTH-3){1'b0}}, in_aluop} : in_opcode;
   assign low_byte    = in_use_bigval ? in_bigval : {in_reg2, in_reg3};
   assign packed_word = {opcode, in_reg1, low_byte};

   // Non-ALU opcodes must have their top bit set; anything else is consumed and flagged.
   assign legal         = in_isaluop || in_opcode[NIB_WIDTH-1];
   assign session_start = (state == IDLE) && start;
   assign take          = in_valid && in_ready;
   assign push          = take && legal;
   assign pop           = mem_we && mem_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    if (pop && (remaining == 1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      busy      = (state != IDLE);
      done      = (state == DONE);
      mem_addr  = addr;
      if (state == LOAD) begin
         in_ready = !fifo_full && (accepted != '0);
         mem_we   = !fifo_empty;
      end
      mem_wdata = mem_we ? fifo_mem[rd_ptr[PTR_W-1:0]] : '0;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= packed_word;
   end

   // count==0 is widened to 2^ADDR_WIDTH so a full-memory session is possible.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         addr      <= '0;
         remaining <= '0;
         accepted  <= '0;
         err       <= 1'b0;
      end else if (session_start) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         addr      <= base_addr;
         remaining <= {(count == '0), count};
         accepted  <= {(count == '0), count};
         err       <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            accepted <= accepted - 1'b1;
         end
         if (take && !legal) err <= 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

`ifdef ENCODE_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || session_start) checksum <= '0;
      else if (pop)               checksum <= checksum ^ mem_wdata;
   end
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// Randomized bench for instr_encode_loader, checked against a field-packing reference model.
module tb_instr_encode_loader;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_ready, in_isaluop, in_use_bigval;
   logic [7:0]  base_addr, count, in_bigval, mem_addr;
   logic [2:0]  in_aluop;
   logic [3:0]  in_opcode, in_reg1, in_reg2, in_reg3;
   logic        mem_we, mem_ready, busy, done, err;
   logic [15:0] mem_wdata;
`ifdef ENCODE_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   instr_encode_loader dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
      .in_valid(in_valid), .in_ready(in_ready), .in_isaluop(in_isaluop), .in_aluop(in_aluop),
      .in_opcode(in_opcode), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_reg3(in_reg3),
      .in_use_bigval(in_use_bigval), .in_bigval(in_bigval), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
      .done(done), .err(err)
`ifdef ENCODE_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       isalu;
      logic [2:0] aluop;
      logic [3:0] opc, r1, r2, r3;
      logic       ub;
      logic [7:0] bv;
   } tup_t;

   tup_t        tq[$];
   logic [7:0]  obs_addr[$], exp_addr[$];
   logic [15:0] obs_data[$], exp_data[$];
   int          done_cnt, stall_hs, unstable, n_checks, n_fail;
   bit          timeout, busy_after, err_after, exp_err;
   logic [15:0] ck_done, exp_ck;

   function automatic tup_t mk(logic isalu, logic [2:0] aluop, logic [3:0] opc, logic [3:0] r1,
                               logic [3:0] r2, logic [3:0] r3, logic ub, logic [7:0] bv);
      tup_t t;
      t.isalu = isalu; t.aluop = aluop; t.opc = opc; t.r1 = r1;
      t.r2 = r2; t.r3 = r3; t.ub = ub; t.bv = bv;
      return t;
   endfunction

   function automatic tup_t rand_tuple(bit want_legal);
      tup_t t = tup_t'({$urandom, $urandom});
      if (want_legal) begin
         if (!t.isalu) t.opc = 4'($urandom_range(15, 8));
      end else begin
         t.isalu = 1'b0;
         t.opc   = 4'($urandom_range(7, 0));
      end
      return t;
   endfunction

   function automatic bit is_legal(tup_t t);
      return t.isalu || (t.opc >= 8);
   endfunction

   // Reference packing: word = opcode*4096 + reg1*256 + low byte.
   function automatic logic [15:0] model_word(tup_t t);
      int op = t.isalu ? int'(t.aluop) : int'(t.opc);
      int lo = t.ub ? int'(t.bv) : int'(t.r2) * 16 + int'(t.r3);
      return 16'(op * 4096 + int'(t.r1) * 256 + lo);
   endfunction

   function automatic void build_expected(logic [7:0] base);
      logic [7:0] a = base;
      exp_addr.delete(); exp_data.delete();
      exp_err = 1'b0; exp_ck = '0;
      foreach (tq[i]) begin
         if (is_legal(tq[i])) begin
            exp_addr.push_back(a);
            exp_data.push_back(model_word(tq[i]));
            exp_ck = exp_ck ^ model_word(tq[i]);
            a = a + 8'd1;
         end else begin
            exp_err = 1'b1;
         end
      end
   endfunction

   task automatic drive_tuple(tup_t t);
      in_isaluop = t.isalu; in_aluop = t.aluop; in_opcode = t.opc; in_reg1 = t.r1;
      in_reg2 = t.r2; in_reg3 = t.r3; in_use_bigval = t.ub; in_bigval = t.bv;
   endtask

   // Drives one session from tq and records every completed write; stimulus only.
   task automatic run_session(logic [7:0] base, logic [7:0] cnt, int stall_first,
                              int stall_pct, int abort_after);
      int          idx = 0, cyc = 0;
      bit          stalled, prev_hold = 1'b0;
      logic [7:0]  p_addr = '0;
      logic [15:0] p_data = '0;
      obs_addr.delete(); obs_data.delete();
      done_cnt = 0; stall_hs = 0; unstable = 0; timeout = 1'b0; ck_done = '0;
      @(negedge clk);
      base_addr = base; count = cnt; start = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      forever begin
         stalled   = (cyc < stall_first) || ($urandom_range(99, 0) < stall_pct);
         mem_ready = !stalled;
         if (idx < tq.size()) begin
            in_valid = 1'b1;
            drive_tuple(tq[idx]);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (prev_hold && (!mem_we || mem_addr !== p_addr || mem_wdata !== p_data)) unstable++;
         prev_hold = mem_we && !mem_ready;
         p_addr = mem_addr; p_data = mem_wdata;
         if (mem_we && mem_ready) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
         end
         if (in_valid && in_ready) begin
            if (cyc < stall_first) stall_hs++;
            idx++;
         end
         if (done) begin
            done_cnt++;
`ifdef ENCODE_CHECKSUM_EN
            ck_done = checksum;
`endif
            break;
         end
         if (abort_after > 0 && obs_addr.size() >= abort_after) return;
         cyc++;
         if (cyc > 3000) begin
            timeout = 1'b1;
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0; mem_ready = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         if (done) done_cnt++;
      end
      busy_after = busy; err_after = err;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
      base_addr = '0; count = '0;
      drive_tuple('0);
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
      n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
      n_checks++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      tq = '{mk(1'b1, 3'd3, 4'h0, 4'h1, 4'h2, 4'h4, 1'b0, 8'h00),
             mk(1'b0, 3'd0, 4'hA, 4'h5, 4'h0, 4'h0, 1'b1, 8'hFF)};
      exp_addr = '{8'h10, 8'h11};
      exp_data = '{16'h3124, 16'hA5FF};
      run_session(8'h10, 8'd2, 0, 0, 0);
      n_checks++; if (timeout) begin n_fail++; $display("FAIL basic_timeout: got timeout expected done"); end
      n_checks++; if (obs_data.size() != 2) begin n_fail++; $display("FAIL basic_write_count: got %0d expected 2", obs_data.size()); end
      for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL basic_write[%0d]: got %h@%h expected %h@%h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
         end
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
      n_checks++; if (err_after !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", err_after); end
      n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
`ifdef ENCODE_CHECKSUM_EN
      n_checks++; if (ck_done !== 16'h94DB) begin n_fail++; $display("FAIL basic_checksum: got %h expected 94db", ck_done); end
`endif
   endtask

   task automatic test_backpressure;
      tq = '{mk(1'b1, 3'd3, 4'h0, 4'h1, 4'h2, 4'h4, 1'b0, 8'h00),
             mk(1'b0, 3'd0, 4'hA, 4'h5, 4'h0, 4'h0, 1'b1, 8'hFF),
             rand_tuple(1'b1), rand_tuple(1'b1)};
      build_expected(8'h10);
      run_session(8'h10, 8'd4, 6, 0, 0);
      n_checks++; if (timeout) begin n_fail++; $display("FAIL bp_timeout: got timeout expected done"); end
      n_checks++; if (stall_hs != 2) begin n_fail++; $display("FAIL bp_accepted_while_stalled: got %0d expected 2", stall_hs); end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d changes expected 0", unstable); end
      n_checks++; if (obs_data.size() != 4) begin n_fail++; $display("FAIL bp_write_count: got %0d expected 4", obs_data.size()); end
      for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL bp_write[%0d]: got %h@%h expected %h@%h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
         end
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_conflict;
      tq = '{mk(1'b0, 3'd0, 4'h5, 4'h3, 4'h3, 4'h3, 1'b0, 8'h00),
             mk(1'b0, 3'd0, 4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00)};
      run_session(8'h40, 8'd1, 0, 0, 0);
      n_checks++; if (timeout) begin n_fail++; $display("FAIL conflict_timeout: got timeout expected done"); end
      n_checks++; if (obs_data.size() != 1) begin n_fail++; $display("FAIL conflict_write_count: got %0d expected 1", obs_data.size()); end
      if (obs_data.size() > 0) begin
         n_checks++;
         if (obs_addr[0] !== 8'h40 || obs_data[0] !== 16'h8000) begin
            n_fail++; $display("FAIL conflict_write: got %h@%h expected 8000@40", obs_data[0], obs_addr[0]);
         end
      end
      n_checks++; if (err_after !== 1'b1) begin n_fail++; $display("FAIL conflict_err: got %b expected 1", err_after); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL conflict_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_wrap;
      tq = '{rand_tuple(1'b1), rand_tuple(1'b1)};
      build_expected(8'hFF);
      run_session(8'hFF, 8'd2, 0, 20, 0);
      n_checks++; if (obs_data.size() != 2) begin n_fail++; $display("FAIL wrap_write_count: got %0d expected 2", obs_data.size()); end
      for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL wrap_write[%0d]: got %h@%h expected %h@%h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
         end
      end
      n_checks++; if (err_after !== 1'b0) begin n_fail++; $display("FAIL wrap_err_cleared: got %b expected 0", err_after); end
   endtask

   task automatic test_mid_reset;
      tq = '{rand_tuple(1'b1), rand_tuple(1'b1), rand_tuple(1'b1)};
      run_session(8'h20, 8'd3, 0, 0, 1);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
      @(negedge clk); #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_mem_we: got %b expected 0", mem_we); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 0", in_ready); end
      n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL abort_mem_addr: got %h expected 00", mem_addr); end
      n_checks++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL abort_mem_wdata: got %h expected 0000", mem_wdata); end
      reset = 1'b0;
      tq = '{rand_tuple(1'b1), rand_tuple(1'b1)};
      build_expected(8'h30);
      run_session(8'h30, 8'd2, 0, 0, 0);
      n_checks++; if (obs_data.size() != 2) begin n_fail++; $display("FAIL restart_write_count: got %0d expected 2", obs_data.size()); end
      for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
         n_checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL restart_write[%0d]: got %h@%h expected %h@%h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
         end
      end
   endtask

   task automatic test_random;
      for (int s = 0; s < 7; s++) begin
         int         n    = (s == 6) ? 256 : int'($urandom_range(10, 1));
         logic [7:0] base = 8'($urandom);
         tq.delete();
         for (int k = 0; k < n; k++) begin
            if (s != 6 && $urandom_range(3, 0) == 0) tq.push_back(rand_tuple(1'b0));
            tq.push_back(rand_tuple(1'b1));
         end
         build_expected(base);
         run_session(base, 8'(n), 0, 30, 0);
         n_checks++; if (timeout) begin n_fail++; $display("FAIL rand%0d_timeout: got timeout expected done", s); end
         n_checks++;
         if (obs_data.size() != exp_data.size()) begin
            n_fail++; $display("FAIL rand%0d_write_count: got %0d expected %0d", s, obs_data.size(), exp_data.size());
         end
         for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
               n_fail++; $display("FAIL rand%0d_write[%0d]: got %h@%h expected %h@%h", s, i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
            end
         end
         n_checks++; if (err_after !== exp_err) begin n_fail++; $display("FAIL rand%0d_err: got %b expected %b", s, err_after, exp_err); end
         n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done_pulses: got %0d expected 1", s, done_cnt); end
`ifdef ENCODE_CHECKSUM_EN
         n_checks++; if (ck_done !== exp_ck) begin n_fail++; $display("FAIL rand%0d_checksum: got %h expected %h", s, ck_done, exp_ck); end
`endif
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_basic;
      test_backpressure;
      test_conflict;
      test_wrap;
      test_mid_reset;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the CPU instruction decoder: packs decoded instruction fields into 16-bit instruction words {opcode, reg1, reg2, reg3}.
- Streams the packed words into program memory at consecutive addresses.
- Sits between a host/boot loader (field producer) and the instruction RAM write port.
- One load session is started by a start pulse and ends after a programmed word count.

Parameters:
- WORD_WIDTH, 16, instruction word width
- NIB_WIDTH, 4, opcode/register field width
- BYTE_WIDTH, 8, big immediate width
- ADDR_WIDTH, 8, program memory address width
- FIFO_DEPTH, 2, packed-word buffer entries (power of 2, at least 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins session (ignored unless IDLE)
- base_addr  in  ADDR_WIDTH  first write address, sampled on start
- count  in  ADDR_WIDTH  words to write, sampled on start; 0 means 2^ADDR_WIDTH
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder can accept tuple
- in_isaluop  in  1  1 = ALU op
- in_aluop  in  3  ALU operation (used when in_isaluop=1)
- in_opcode  in  NIB_WIDTH  full opcode (used when in_isaluop=0)
- in_reg1, in_reg2, in_reg3  in  NIB_WIDTH each  register fields
- in_use_bigval  in  1  1 = low byte taken from in_bigval
- in_bigval  in  BYTE_WIDTH  8-bit immediate
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  WORD_WIDTH  write data
- mem_ready  in  1  memory accepts write this cycle
- busy  out  1  session active
- done  out  1  one-cycle pulse after the last write completes
- err  out  1  sticky opcode-conflict flag; cleared on start or reset

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. FIFO is emptied and the state goes to IDLE.
- Packing:
  - opcode = isaluop ? {1'b0, aluop} : in_opcode.
  - low byte = use_bigval ? bigval : {reg2, reg3}.
  - word = {opcode, reg1, low byte}.
  - A decoder fed this word reproduces isaluop, aluop, reg1, bigval and smallval.
- Conflict: in_isaluop=0 with in_opcode[3]=0 is illegal.
  - The tuple is consumed (handshake completes) but not enqueued.
  - err is set next cycle.
  - Address and remaining count are unchanged.
- States:
  - IDLE: in_ready=0. On start go to LOAD, with addr<=base_addr, remaining<=count, accepted<=count, err<=0.
  - LOAD:
    - in_ready = (FIFO not full) && (accepted != 0).
    - A tuple is accepted on in_valid && in_ready; the packed word enters the FIFO on the next edge, so there is 1 cycle of latency to the FIFO.
    - mem_we = FIFO not empty; mem_wdata = FIFO head; mem_addr = addr.
    - Write completes on mem_we && mem_ready: pop the FIFO, addr<=addr+1 (wraps mod 2^ADDR_WIDTH), remaining<=remaining-1.
    - When the completing write has remaining==1, go to DONE.
  - DONE: done=1 for one cycle, then IDLE. busy=1 in LOAD and DONE.
- Simultaneous push and pop on a full FIFO is allowed only via pop-then-push. in_ready is not combinationally dependent on mem_ready.
- mem_we, mem_addr and mem_wdata hold stable while mem_we && !mem_ready.
- Accepted-but-illegal tuples do not decrement accepted; only legal tuples count toward count.
- start while in LOAD or DONE is ignored.
- reset mid-session: abort immediately. Buffered words are discarded and all outputs return to reset values on the next edge.

Optional Feature:
- Macro ENCODE_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (WORD_WIDTH): XOR of all words written this session.
  - Cleared to 0 on start and on reset.
  - Updated on each completed write.
  - Valid (final) in the cycle done=1; holds until the next start.
- Undefined: port absent, no added logic.

Test Plan:
- Start base_addr=0x10, count=2, mem_ready=1. Feed ALU tuple aluop=3, reg1=1, reg2=2, reg3=4, use_bigval=0, then non-ALU opcode=0xA, reg1=5, bigval=0xFF, use_bigval=1.
  -> writes 0x3124@0x10 and 0xA5FF@0x11, done pulses once, err=0.
- Same session with mem_ready held 0 for 5 cycles.
  -> in_ready drops after 2 buffered words; mem_addr/mem_wdata stable; both words written in order once mem_ready=1.
- Non-ALU tuple with opcode=0x5 mid-session, count=1.
  -> err=1, no write. The next legal tuple 0x8000 is written at base_addr; done follows.
- base_addr=0xFF, count=2.
  -> writes at 0xFF then 0x00.
- Assert reset after 1 of 3 writes.
  -> mem_we=0, busy=0, state IDLE next cycle. A new start then works from its base_addr.
- With ENCODE_CHECKSUM_EN, the first scenario.
  -> checksum = 0x3124 ^ 0xA5FF = 0x94DB when done=1.
